writeback_unit: RTL and testbench

Writeback stage directly upstream of the register file's single write port. Merges ALU/CSR results from the execute unit with variable-latency load data from the LSU, aligns and sign/zero-extends load data, and drives one registered write (`rf_wen`/`rf_rd`/`rf_data`) per cycle. Keeps a pending-load scoreboard and raises a decode-stage stall on read-after-write hazards.

---
 rtl/writeback_unit.sv | 154 +++++++++++++++
 tb/tb_writeback_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage in front of the register file's single
// write port. Arbitrates LSU load returns (priority) against EXU results,
// extracts and extends load data, and registers one write per cycle. A
// pending-load scoreboard plus the in-flight write drive the decode stall.
//
// Optional feature macro: WRITEBACK_INSTRET_EN
//   defined     -> 64-bit retired-instruction counter on instret
//   not defined -> counter not built, instret tied to 0
module writeback_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_wen,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_issue,
  input  logic [ADDR_WIDTH-1:0] lsu_issue_rd,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [2:0]            lsu_funct3,
  input  logic [2:0]            lsu_offset,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  hz_stall,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data,
  output logic [63:0]           instret
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic [NREG-1:0]       sb_q, sb_d;

  logic                  exu_xfer;
  logic                  retire;
  logic [2:0]            off_eff;
  logic [5:0]            rot_sh;
  logic [DATA_WIDTH-1:0] rot;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  hz_rs1, hz_rs2;

  // LSU returns cannot be backpressured, so they always win the write port.
  assign exu_ready = !lsu_valid;
  assign exu_xfer  = exu_valid && exu_ready;
  assign retire    = lsu_valid || exu_xfer;

  // Rotate the word so the addressed byte lands in bit 0; rotation makes
  // misaligned accesses wrap around the word instead of reading past it.
  always_comb begin
    off_eff = (DATA_WIDTH == 64) ? lsu_offset : {1'b0, lsu_offset[1:0]};
    rot_sh  = {off_eff, 3'b000};
    rot     = DATA_WIDTH'({lsu_rdata, lsu_rdata} >> rot_sh);
  end

  // Size selection and sign/zero extension; 32-bit builds fold ld/lwu onto lw.
  always_comb begin
    load_ext = rot;
    case (lsu_funct3)
      3'b000: load_ext = DATA_WIDTH'($signed(rot[7:0]));
      3'b001: load_ext = DATA_WIDTH'($signed(rot[15:0]));
      3'b010: load_ext = DATA_WIDTH'($signed(rot[31:0]));
      3'b011: load_ext = (DATA_WIDTH == 32) ? DATA_WIDTH'($signed(rot[31:0])) : rot;
      3'b100: load_ext = DATA_WIDTH'(rot[7:0]);
      3'b101: load_ext = DATA_WIDTH'(rot[15:0]);
      3'b110: load_ext = (DATA_WIDTH == 32) ? DATA_WIDTH'($signed(rot[31:0]))
                                            : DATA_WIDTH'(rot[31:0]);
      default: load_ext = rot;
    endcase
  end

  // Next write-port contents; rd/data hold when nothing transfers.
  always_comb begin
    rf_wen_d  = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (lsu_valid) begin
      rf_wen_d  = (lsu_rd != '0);
      rf_rd_d   = lsu_rd;
      rf_data_d = load_ext;
    end else if (exu_xfer) begin
      rf_wen_d  = exu_wen && (exu_rd != '0);
      rf_rd_d   = exu_rd;
      rf_data_d = exu_data;
    end
  end

  // Scoreboard update: clear on return first so a same-cycle reissue wins.
  always_comb begin
    sb_d = sb_q;
    if (lsu_valid)
      sb_d[lsu_rd] = 1'b0;
    if (lsu_issue && (lsu_issue_rd != '0))
      sb_d[lsu_issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Registered write port and scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q  <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      sb_q      <= '0;
    end else begin
      rf_wen_q  <= rf_wen_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      sb_q      <= sb_d;
    end
  end

  // Stall on a pending load or on a write still one cycle from commit.
  always_comb begin
    hz_rs1   = (rs1 != '0) && (sb_q[rs1] || (rf_wen_q && (rf_rd_q == rs1)));
    hz_rs2   = (rs2 != '0) && (sb_q[rs2] || (rf_wen_q && (rf_rd_q == rs2)));
    hz_stall = hz_rs1 || hz_rs2;
  end

  assign rf_wen  = rf_wen_q;
  assign rf_rd   = rf_rd_q;
  assign rf_data = rf_data_q;

`ifdef WRITEBACK_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q + 64'(retire);
  end

  // Retired-instruction counter, wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instret_q <= '0;
    else
      instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret       = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed testbench for writeback_unit (ADDR_WIDTH=5, DATA_WIDTH=32).
module tb_writeback_unit;

  logic        clk;
  logic        rst_n;
  logic        exu_valid, exu_ready, exu_wen;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_issue;
  logic [4:0]  lsu_issue_rd;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_funct3, lsu_offset;
  logic [31:0] lsu_rdata;
  logic [4:0]  rs1, rs2;
  logic        hz_stall, rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [63:0] instret;

  int n_tests = 0;
  int n_fail  = 0;
  longint unsigned n_ret = 0;

  writeback_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
    .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_funct3(lsu_funct3),
    .lsu_offset(lsu_offset), .lsu_rdata(lsu_rdata),
    .rs1(rs1), .rs2(rs2), .hz_stall(hz_stall),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ir_exp(input longint unsigned n);
`ifdef WRITEBACK_INSTRET_EN
    return n;
`else
    return (n == 0) ? 64'd0 : 64'd0;
`endif
  endfunction

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [2:0] off,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [31:0] exp);
    lsu_valid = 1'b1; lsu_funct3 = f3; lsu_offset = off; lsu_rdata = rdata; lsu_rd = rd;
    tick();
    lsu_valid = 1'b0;
    n_ret++;
    #1;
    chk({tag, "_wen"}, 64'(rf_wen), 64'd1);
    chk({tag, "_rd"}, 64'(rf_rd), 64'(rd));
    chk({tag, "_data"}, 64'(rf_data), 64'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    exu_valid = 0; exu_wen = 0; exu_rd = 0; exu_data = 0;
    lsu_issue = 0; lsu_issue_rd = 0; lsu_valid = 0; lsu_rd = 0;
    lsu_funct3 = 0; lsu_offset = 0; lsu_rdata = 0;
    rs1 = 5'd3; rs2 = 5'd4;
    #23 rst_n = 1'b1;
    tick();
    #1;
    chk("rst_wen", 64'(rf_wen), 64'd0);
    chk("rst_rd", 64'(rf_rd), 64'd0);
    chk("rst_data", 64'(rf_data), 64'd0);
    chk("rst_stall", 64'(hz_stall), 64'd0);
    chk("rst_instret", instret, ir_exp(0));
    chk("rst_ready", 64'(exu_ready), 64'd1);

    // EXU write to x5
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd5; exu_data = 32'h1234;
    tick();
    exu_valid = 0; rs1 = 5'd5;
    n_ret++;
    #1;
    chk("exu_wen", 64'(rf_wen), 64'd1);
    chk("exu_rd", 64'(rf_rd), 64'd5);
    chk("exu_data", 64'(rf_data), 64'h1234);
    chk("exu_stall_inflight", 64'(hz_stall), 64'd1);
    chk("exu_instret", instret, ir_exp(n_ret));
    tick();
    chk("idle_wen", 64'(rf_wen), 64'd0);
    chk("idle_rd_hold", 64'(rf_rd), 64'd5);
    chk("idle_data_hold", 64'(rf_data), 64'h1234);
    chk("idle_stall", 64'(hz_stall), 64'd0);
    rs1 = 5'd0; rs2 = 5'd0;

    // Load extraction from 0x80FF7F01
    do_load("lb3",  3'b000, 3'd3, 32'h80FF7F01, 5'd11, 32'hFFFFFF80);
    do_load("lbu3", 3'b100, 3'd3, 32'h80FF7F01, 5'd12, 32'h00000080);
    do_load("lh2",  3'b001, 3'd2, 32'h80FF7F01, 5'd13, 32'hFFFF80FF);
    do_load("lhu0", 3'b101, 3'd0, 32'h80FF7F01, 5'd14, 32'h00007F01);
    do_load("lh3",  3'b001, 3'd3, 32'h80FF7F01, 5'd15, 32'h00000180);
    do_load("ld1",  3'b011, 3'd1, 32'h80FF7F01, 5'd16, 32'h0180FF7F);
    do_load("lb5",  3'b000, 3'd5, 32'h80FF7F01, 5'd17, 32'h0000007F);
    chk("load_instret", instret, ir_exp(n_ret));

    // Collision: LSU first, EXU next cycle
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd9; exu_data = 32'hAAAA;
    lsu_valid = 1; lsu_rd = 5'd10; lsu_funct3 = 3'b010; lsu_offset = 0; lsu_rdata = 32'h55;
    #1;
    chk("col_ready0", 64'(exu_ready), 64'd0);
    tick();
    lsu_valid = 0;
    n_ret++;
    #1;
    chk("col_lsu_rd", 64'(rf_rd), 64'd10);
    chk("col_lsu_data", 64'(rf_data), 64'h55);
    chk("col_ready1", 64'(exu_ready), 64'd1);
    tick();
    exu_valid = 0;
    n_ret++;
    #1;
    chk("col_exu_wen", 64'(rf_wen), 64'd1);
    chk("col_exu_rd", 64'(rf_rd), 64'd9);
    chk("col_exu_data", 64'(rf_data), 64'hAAAA);
    chk("col_instret", instret, ir_exp(n_ret));

    // Scoreboard on x7
    rs2 = 5'd7;
    lsu_issue = 1; lsu_issue_rd = 5'd7;
    tick();
    lsu_issue = 0;
    #1;
    chk("sb_set", 64'(hz_stall), 64'd1);
    tick();
    chk("sb_hold", 64'(hz_stall), 64'd1);
    lsu_valid = 1; lsu_rd = 5'd7; lsu_funct3 = 3'b010; lsu_rdata = 32'h77;
    lsu_issue = 1; lsu_issue_rd = 5'd7;
    tick();
    lsu_valid = 0; lsu_issue = 0;
    n_ret++;
    #1;
    chk("sb_setwins_a", 64'(hz_stall), 64'd1);
    tick();
    chk("sb_setwins_wen", 64'(rf_wen), 64'd0);
    chk("sb_setwins_b", 64'(hz_stall), 64'd1);
    lsu_valid = 1; lsu_rd = 5'd7;
    tick();
    lsu_valid = 0;
    n_ret++;
    #1;
    chk("sb_ret_inflight", 64'(hz_stall), 64'd1);
    tick();
    chk("sb_cleared", 64'(hz_stall), 64'd0);

    // x0 handling and non-writing retire
    rs2 = 5'd0;
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd0; exu_data = 32'hDEAD;
    tick();
    exu_valid = 0;
    n_ret++;
    #1;
    chk("x0_wen", 64'(rf_wen), 64'd0);
    chk("x0_instret", instret, ir_exp(n_ret));
    exu_valid = 1; exu_wen = 0; exu_rd = 5'd6; exu_data = 32'hBEEF;
    rs1 = 5'd6;
    tick();
    exu_valid = 0;
    n_ret++;
    #1;
    chk("nowen_wen", 64'(rf_wen), 64'd0);
    chk("nowen_stall", 64'(hz_stall), 64'd0);
    chk("nowen_instret", instret, ir_exp(n_ret));
    rs1 = 5'd0;
    lsu_issue = 1; lsu_issue_rd = 5'd0;
    tick();
    lsu_issue = 0;
    #1;
    chk("x0_issue_stall", 64'(hz_stall), 64'd0);

    // Reset mid-operation
    rs1 = 5'd12;
    lsu_issue = 1; lsu_issue_rd = 5'd12;
    tick();
    lsu_issue = 0;
    #1;
    chk("mid_pending", 64'(hz_stall), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 64'(hz_stall), 64'd0);
    chk("mid_rst_rd", 64'(rf_rd), 64'd0);
    chk("mid_rst_data", 64'(rf_data), 64'd0);
    chk("mid_rst_instret", instret, ir_exp(0));
    #10 rst_n = 1'b1;
    tick();
    chk("post_rst_stall", 64'(hz_stall), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
